serial_capture_ctrl: RTL

//   Sequencing controller for the serial-in shift-register / bit-counter datapath.
//   On a request it clears the datapath (set pulse), enables shifting for exactly WIDTH

---
 rtl/serial_capture_ctrl_pkg.sv | 21 ++
 rtl/serial_capture_ctrl_shift_count.sv | 39 +++
 rtl/serial_capture_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/serial_capture_ctrl_pkg.sv
// Shared definitions for the serial capture controller: state encoding and default sizes.
package serial_capture_ctrl_pkg;

    // Default frame geometry; 2**SCC_CNT_W must equal SCC_WIDTH.
    localparam int unsigned SCC_WIDTH = 8;
    localparam int unsigned SCC_CNT_W = 3;

    // Controller states, encoding fixed so the state value is meaningful on a debug bus.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // True while the datapath is owned by an in-flight frame.
    function automatic logic state_is_busy(input state_t s);
        return (s == ST_CLEAR) || (s == ST_SHIFT);
    endfunction

endpackage

// File: rtl/serial_capture_ctrl_shift_count.sv
// Serial-in shift register with a wrapping bit counter and a last-bit carry pulse.
module shift_count_unit
    import serial_capture_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = SCC_WIDTH,
    parameter int unsigned CNT_W = SCC_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             serin,
    output logic [WIDTH-1:0] shreg,
    output logic [CNT_W-1:0] cnt,
    output logic             co
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Shift in MSB-first, count bits, and pulse co on the edge that takes the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
            co    <= 1'b0;
        end else if (clr) begin
            shreg <= '0;
            cnt   <= '0;
            co    <= 1'b0;
        end else if (en) begin
            shreg <= {shreg[WIDTH-2:0], serin};
            cnt   <= cnt + CNT_W'(1);
            co    <= (cnt == CNT_LAST);
        end else begin
            co    <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_capture_ctrl.sv
// Sequencing controller: clears the shift/count datapath, captures WIDTH serial bits,
// then presents the word under a valid/ready handshake.
module serial_capture_ctrl
    import serial_capture_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = SCC_WIDTH,
    parameter int unsigned CNT_W = SCC_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             abort,
    input  logic             serin,
    input  logic             data_ready,
    output logic             busy,
    output logic [CNT_W-1:0] cnen,
    output logic             co,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             ovr
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic             dp_clr;
    logic             dp_en;
    logic             capture;
    logic [WIDTH-1:0] shreg;
    logic             shreg_msb_unused;

    // The oldest bit leaves the register on the capture edge; the word is rebuilt with serin.
    assign shreg_msb_unused = shreg[WIDTH-1];

    // Final bit of the frame is being shifted in on this edge.
    assign capture = dp_en && (cnen == CNT_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; abort overrides every transition.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state_nxt = ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    state_nxt = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (cnen == CNT_LAST) begin
                        state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (data_ready) begin
                        state_nxt = go ? ST_CLEAR : ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State-decoded outputs and datapath controls; abort also zeroes the counter.
    always_comb begin
        busy       = state_is_busy(state);
        data_valid = 1'b0;
        dp_clr     = abort;
        dp_en      = 1'b0;
        case (state)
            ST_CLEAR: dp_clr     = 1'b1;
            ST_SHIFT: dp_en      = !abort;
            ST_HOLD:  data_valid = 1'b1;
            default:  ;
        endcase
    end

    // Datapath owning bit sampling, bit count and the last-bit pulse.
    shift_count_unit #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shift_count (
        .clk   (clk),
        .rst   (rst),
        .clr   (dp_clr),
        .en    (dp_en),
        .serin (serin),
        .shreg (shreg),
        .cnt   (cnen),
        .co    (co)
    );

    // Captured word register and sticky overrun flag; abort leaves both untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            ovr      <= 1'b0;
        end else begin
            if (capture) begin
                data_out <= {shreg[WIDTH-2:0], serin};
            end
            if (!abort) begin
                if (state == ST_CLEAR) begin
                    ovr <= 1'b0;
                end else if ((state == ST_HOLD) && go && !data_ready) begin
                    ovr <= 1'b1;
                end
            end
        end
    end

endmodule
